// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE_WAIT,
        RUN,
        FAIL
    } pll_sup_state_t;

    localparam int unsigned LOSS_CNT_W = 8;

    // Width of a counter that must reach (largest of a, b, c) - 1; never below 1 bit.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a synchronous reset value, for any bus width.
module sync_2ff #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives PLL reset, waits for a stable lock, releases the core reset and
// tracks retries / lock losses.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 500000,
    parameter int unsigned STABLE_CYCLES = 5000,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  restart_req,
    output logic                  pll_rst,
    output logic                  sys_reset,
    output logic                  ready,
    output logic                  fail,
    output logic [1:0]            retry_count,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    localparam int unsigned CNT_W = cnt_width(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

    pll_sup_state_t   state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             locked_s;
    logic             cnt_clr, cnt_run;
    logic             retry_inc, retry_clr, loss_inc;

    sync_2ff #(
        .WIDTH       (1),
        .RESET_VALUE (1'b0)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= RESET_PLL;
            cnt         <= '0;
            retry_count <= '0;
            loss_count  <= '0;
        end else begin
            state <= state_next;
            if (cnt_clr)
                cnt <= '0;
            else if (cnt_run)
                cnt <= cnt + CNT_W'(1);
            if (retry_clr)
                retry_count <= '0;
            else if (retry_inc)
                retry_count <= retry_count + 2'd1;
            if (loss_inc && loss_count != '1)
                loss_count <= loss_count + LOSS_CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        retry_inc  = 1'b0;
        retry_clr  = 1'b0;
        loss_inc   = 1'b0;
        cnt_run    = (state == RESET_PLL) || (state == WAIT_LOCK) || (state == STABLE_WAIT);

        // A restart wins over everything, including a restart during RESET_PLL,
        // which has no state change and so clears the counter explicitly.
        if (restart_req) begin
            state_next = RESET_PLL;
            retry_clr  = 1'b1;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                RESET_PLL: begin
                    if (cnt == RST_LAST)
                        state_next = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_next = STABLE_WAIT;
                    end else if (cnt == TO_LAST) begin
                        if (retry_count == RETRY_MAX) begin
                            state_next = FAIL;
                        end else begin
                            state_next = RESET_PLL;
                            retry_inc  = 1'b1;
                        end
                    end
                end
                STABLE_WAIT: begin
                    if (!locked_s) begin
                        state_next = WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        state_next = RUN;
                        retry_clr  = 1'b1;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_next = WAIT_LOCK;
                        loss_inc   = 1'b1;
                    end
                end
                FAIL: begin
                    state_next = FAIL;
                end
                default: begin
                    state_next = RESET_PLL;
                end
            endcase
        end

        if (state_next != state)
            cnt_clr = 1'b1;
    end

    always_comb begin
        pll_rst   = (state == RESET_PLL);
        sys_reset = (state != RUN);
        ready     = (state == RUN);
        fail      = (state == FAIL);
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench: a phase/elapsed-time model predicts outputs per edge, a
// negedge monitor compares, and directed timing checks cover the key latencies.
module tb_pll_lock_supervisor;

    localparam int unsigned RC = 4;
    localparam int unsigned TO = 20;
    localparam int unsigned SC = 8;
    localparam int unsigned MR = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart_req = 1'b0;
    logic       pll_rst, sys_reset, ready, fail;
    logic [1:0] retry_count;
    logic [7:0] loss_count;

    int n_cmp = 0;
    int n_err = 0;

    pll_lock_supervisor #(
        .RST_CYCLES    (RC),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (SC),
        .MAX_RETRIES   (MR)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .restart_req (restart_req),
        .pll_rst     (pll_rst),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .fail        (fail),
        .retry_count (retry_count),
        .loss_count  (loss_count)
    );

    always #5 refclk = ~refclk;

    // ---------------- reference model ----------------
    typedef enum int {M_RST, M_WAIT, M_STAB, M_RUN, M_FAIL} mphase_t;
    mphase_t m_phase = M_RST;
    int      m_cyc = 0, m_start = 0, m_retries = 0, m_losses = 0;
    bit      m_s0 = 1'b0, m_s1 = 1'b0;
    logic [13:0] exp_q[$];

    task automatic model_edge();
        bit      ls;
        int      el;
        mphase_t nxt;
        ls  = m_s1;
        el  = m_cyc - m_start;
        nxt = m_phase;
        if (rst) begin
            nxt       = M_RST;
            m_retries = 0;
            m_losses  = 0;
            m_s0      = 1'b0;
            m_s1      = 1'b0;
            m_start   = m_cyc + 1;
        end else begin
            m_s1 = m_s0;
            m_s0 = pll_locked;
            if (restart_req) begin
                nxt       = M_RST;
                m_retries = 0;
            end else begin
                case (m_phase)
                    M_RST:  if (el == RC - 1) nxt = M_WAIT;
                    M_WAIT: begin
                        if (ls) nxt = M_STAB;
                        else if (el == TO - 1) begin
                            if (m_retries == MR) nxt = M_FAIL;
                            else begin
                                m_retries++;
                                nxt = M_RST;
                            end
                        end
                    end
                    M_STAB: begin
                        if (!ls) nxt = M_WAIT;
                        else if (el == SC - 1) begin
                            nxt       = M_RUN;
                            m_retries = 0;
                        end
                    end
                    M_RUN: begin
                        if (!ls) begin
                            nxt      = M_WAIT;
                            m_losses = (m_losses < 255) ? m_losses + 1 : 255;
                        end
                    end
                    default: nxt = m_phase;
                endcase
            end
            if (nxt != m_phase || restart_req) m_start = m_cyc + 1;
        end
        m_phase = nxt;
        m_cyc++;
        exp_q.push_back({m_phase == M_RST, m_phase != M_RUN, m_phase == M_RUN,
                         m_phase == M_FAIL, 2'(m_retries), 8'(m_losses)});
    endtask

    // ---------------- monitor ----------------
    always @(negedge refclk) begin
        logic [13:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {pll_rst, sys_reset, ready, fail, retry_count, loss_count};
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL outputs t=%0t: got rst/sys/rdy/fail/retry/loss=%b want %b", $time, a, e);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        model_edge();
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic count_to_ready(output int k);
        k = 0;
        do begin
            step();
            k++;
        end while (!ready && k < 100);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, pulses, saw;
        logic prev;

        // Clean bring-up
        pll_locked = 1'b0;
        do_reset();
        chk("reset_pll_rst", int'(pll_rst), 1);
        chk("reset_loss", int'(loss_count), 0);
        n = 0;
        repeat (10) begin
            if (pll_rst) n++;
            step();
        end
        chk("bringup_pulse_len", n, RC);
        pll_locked = 1'b1;
        count_to_ready(k);
        chk("bringup_ready_lat", k, SC + 3);
        chk("bringup_sys_reset", int'(sys_reset), 0);

        // Lock loss in RUN, then saturation
        pll_locked = 1'b0;
        k = 0;
        saw = 0;
        do begin
            step();
            k++;
            if (pll_rst) saw = 1;
        end while (ready && k < 20);
        chk("loss_ready_lat", k, 3);
        chk("loss_count_first", int'(loss_count), 1);
        repeat (5) begin
            step();
            if (pll_rst) saw = 1;
        end
        chk("loss_no_pll_rst", saw, 0);
        for (int i = 0; i < 299; i++) begin
            pll_locked = 1'b1;
            count_to_ready(k);
            pll_locked = 1'b0;
            repeat (4) step();
        end
        chk("loss_saturate", int'(loss_count), 255);

        // Mid-operation reset from RUN
        pll_locked = 1'b1;
        count_to_ready(k);
        chk("pre_rst_ready", int'(ready), 1);
        do_reset();
        chk("midrst_outputs", int'({pll_rst, sys_reset, ready, fail}), 4'b1100);
        chk("midrst_counts", int'({retry_count, loss_count}), 0);
        n = 0;
        while (pll_rst && n < 20) begin
            n++;
            step();
        end
        chk("midrst_pulse_len", n, RC);

        // Timeout and fail
        pll_locked = 1'b0;
        do_reset();
        pulses = 1;
        prev   = pll_rst;
        repeat (100) begin
            step();
            if (pll_rst && !prev) pulses++;
            prev = pll_rst;
        end
        chk("timeout_pulses", pulses, MR + 1);
        chk("fail_set", int'(fail), 1);
        chk("fail_sys_reset", int'(sys_reset), 1);
        chk("fail_retry", int'(retry_count), MR);
        restart_req = 1'b1;
        step();
        restart_req = 1'b0;
        chk("restart_fail_clr", int'(fail), 0);
        n = 0;
        while (pll_rst && n < 20) begin
            n++;
            step();
        end
        chk("restart_pulse_len", n, RC);

        // restart_req coincident with final timeout
        do_reset();
        n = 0;
        while (!(m_phase == M_WAIT && m_retries == MR && (m_cyc - m_start) == TO - 1) && n < 300) begin
            step();
            n++;
        end
        restart_req = 1'b1;
        step();
        restart_req = 1'b0;
        chk("simul_pll_rst", int'(pll_rst), 1);
        chk("simul_fail", int'(fail), 0);
        chk("simul_retry", int'(retry_count), 0);
        repeat (30) step();

        // Stability glitch at stable count 5
        do_reset();
        repeat (6) step();
        pll_locked = 1'b1;
        repeat (6) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        count_to_ready(k);
        chk("glitch_relock_lat", k, SC + 3);
        chk("glitch_retry", int'(retry_count), 0);

        // Random traffic
        do_reset();
        repeat (200) begin
            pll_locked = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 30);
            repeat (n) begin
                restart_req = ($urandom_range(0, 39) == 0);
                rst         = ($urandom_range(0, 299) == 0);
                step();
            end
            restart_req = 1'b0;
            rst         = 1'b0;
        end

        repeat (2) @(negedge refclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequencer on the far side of the system PLL: drives the PLL `rst` input and watches its asynchronous `locked` output. It holds the core in reset until lock is stable, retries the PLL on lock timeout, and re-enters reset on lock loss. It runs on the 50 MHz reference clock, which is always present, and feeds `sys_reset` to the core reset synchronizers in the `outclk_0` domain.

## Interface
Parameters:
- `RST_CYCLES`, default 16: length of the `pll_rst` pulse, in refclk cycles.
- `LOCK_TIMEOUT`, default 500000: refclk cycles to wait for lock (10 ms).
- `STABLE_CYCLES`, default 5000: consecutive locked cycles required before release (100 µs).
- `MAX_RETRIES`, default 3: PLL resets allowed after the first one before FAIL.

Ports:
- `refclk` in 1: the single clock, 50 MHz.
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: PLL `locked`, asynchronous to refclk.
- `restart_req` in 1: single-cycle request to re-reset the PLL, e.g. on a video-mode change.
- `pll_rst` out 1: to the PLL `rst` input.
- `sys_reset` out 1: core reset request, active-high.
- `ready` out 1: PLL locked and stable.
- `fail` out 1: retries exhausted; sticky.
- `retry_count` out 2: retries consumed in the current attempt.
- `loss_count` out 8: lock-loss events seen while in RUN; saturates at 255.

## Operation
- Synchronizer: `pll_locked` passes through two flops to give `locked_s`. No other logic sees `pll_locked` directly.
- One counter `cnt`, sized `$clog2(max(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES))`, cleared on every state change.
- All outputs are Moore, decoded from registered state.
- States:
  - RESET_PLL: `pll_rst=1`. Lasts exactly `RST_CYCLES` cycles, then goes to WAIT_LOCK.
  - WAIT_LOCK: `pll_rst=0`, `sys_reset=1`.
    - `locked_s=1`: go to STABLE_WAIT.
    - `cnt==LOCK_TIMEOUT-1` with no lock: if `retry_count==MAX_RETRIES`, go to FAIL. Otherwise increment `retry_count` and go to RESET_PLL.
  - STABLE_WAIT: `sys_reset=1`.
    - `locked_s=0`: go to WAIT_LOCK. This does not consume a retry.
    - `cnt==STABLE_CYCLES-1` with `locked_s=1`: go to RUN.
  - RUN: `sys_reset=0`, `ready=1`, `retry_count` cleared.
    - `locked_s=0`: go to WAIT_LOCK and increment `loss_count` (saturating at 255). The PLL is not reset; it re-locks on its own.
  - FAIL: `pll_rst=0`, `sys_reset=1`, `fail=1`. Exits only on `rst` or `restart_req`.
- Priority:
  - `restart_req=1` overrides every transition in every state: go to RESET_PLL and clear `retry_count`. `loss_count` is kept.
  - A request arriving during RESET_PLL restarts the pulse from `cnt=0`.
- `rst` mid-operation: all state is returned to reset values on the next edge, including `loss_count`.

## Timing
- Reset values, asserted on the edge where `rst=1` is sampled:
  - state RESET_PLL with `cnt=0`
  - `pll_rst=1`, `sys_reset=1`, `ready=0`, `fail=0`
  - `retry_count=0`, `loss_count=0`
  - both synchronizer flops = 0
- The `pll_rst` pulse is `RST_CYCLES` cycles after `rst` deasserts, plus however many cycles `rst` is held.
- Lock latency: `locked_s` follows `pll_locked` after 2 edges. WAIT_LOCK leaves on the 3rd edge.
- `ready` rises and `sys_reset` falls `STABLE_CYCLES+3` edges after a clean `pll_locked` rise seen in WAIT_LOCK.
- Loss latency: `ready=0` and `sys_reset=1` take effect 3 edges after `pll_locked` falls in RUN.
- A `locked_s` glitch shorter than `STABLE_CYCLES` during STABLE_WAIT never releases reset.
- `ready` and `fail` are never high together.
- `sys_reset` is refclk-synchronous. Consumers must re-synchronize it into their own domain.

## Structure
- Shared package `pll_sup_pkg` holds:
  - enum `pll_sup_state_t` with values RESET_PLL, WAIT_LOCK, STABLE_WAIT, RUN, FAIL
  - `LOSS_CNT_W = 8`
  - the counter-width helper function
- One sub-module, `sync_2ff`: parameterised-width two-flop synchronizer with a synchronous reset value. Reusable elsewhere.

## Test plan
Use `RST_CYCLES=4`, `LOCK_TIMEOUT=20`, `STABLE_CYCLES=8`, `MAX_RETRIES=2`.
- Clean bring-up: release `rst`, raise `pll_locked` 10 cycles later and hold it. Expect `pll_rst` high for exactly 4 cycles, and `ready=1`/`sys_reset=0` exactly 11 edges after the `pll_locked` rise.
- Timeout and fail: hold `pll_locked=0`. Expect 3 `pll_rst` pulses with `retry_count` stepping 0, 1, 2, then `fail=1` and `sys_reset=1`, stable thereafter. A `restart_req` pulse from there produces a new 4-cycle `pll_rst` and `fail=0`.
- Stability glitch: in STABLE_WAIT, drop `pll_locked` for 1 cycle at stable count 5. Expect no release and a return to WAIT_LOCK with `retry_count` unchanged. After a clean relock, `ready` rises 11 edges after the rise.
- Lock loss in RUN: drop `pll_locked`. Expect `ready=0` 3 edges later and `loss_count` 0→1 with no `pll_rst` pulse. Drive 300 losses and expect `loss_count` to saturate at 255.
- Simultaneous events: `restart_req` on the same edge that the timeout expires. Expect RESET_PLL with `retry_count=0`, not FAIL.
- Mid-operation reset: assert `rst` for 1 cycle while in RUN. Expect all outputs at reset values on the next edge and a full 4-cycle `pll_rst` pulse afterward.
